// File: rtl/mem_port_arbiter.sv
// Shares one split-handshake memory port between IF (inst) and MEM (data) requesters; owner FIFO routes data_ok back in order.
// Zero added latency; optional round-robin grant under MEM_ARB_RR_EN (default: fixed data priority).
module mem_port_arbiter #(
    parameter int OT_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_req,
    input  logic [ADDR_W-1:0]        inst_addr,
    output logic                     inst_addr_ok,
    output logic                     inst_data_ok,
    output logic [DATA_W-1:0]        inst_rdata,
    input  logic                     inst_cancel,
    input  logic                     data_req,
    input  logic                     data_wr,
    input  logic [1:0]               data_size,
    input  logic [DATA_W/8-1:0]      data_wstrb,
    input  logic [ADDR_W-1:0]        data_addr,
    input  logic [DATA_W-1:0]        data_wdata,
    output logic                     data_addr_ok,
    output logic                     data_data_ok,
    output logic [DATA_W-1:0]        data_rdata,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic [DATA_W/8-1:0]      mem_wstrb,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [$clog2(OT_DEPTH):0] ot_cnt,
    output logic                     resp_err
);

    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    owner_t                sel;
    owner_t                lock_own;
    logic                  locked;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic [OT_DEPTH-1:0]   own_q;
    logic [OT_DEPTH-1:0]   drop_q;
    logic [OT_DEPTH-1:0]   own_nxt;
    logic [OT_DEPTH-1:0]   drop_nxt;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  head_own;
    logic                  head_drop;

    assign full  = (cnt == CW'(OT_DEPTH));
    assign empty = (cnt == '0);

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;

    always_comb begin
        sel = OWN_INST;
        if (locked)
            sel = lock_own;
        else if (data_req && inst_req)
            sel = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
        else if (data_req)
            sel = OWN_DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= OWN_INST;
        else if (push)
            last_grant <= sel;
    end
`else
    always_comb begin
        sel = OWN_INST;
        if (locked)
            sel = lock_own;
        else if (data_req)
            sel = OWN_DATA;
    end
`endif

    // A pop in the same cycle as full does not open a slot for a push.
    assign mem_req = (inst_req | data_req) & ~full;
    assign push    = mem_req & mem_addr_ok;
    assign pop     = mem_data_ok & ~empty;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd2;
        mem_wstrb = '0;
        mem_wdata = '0;
        mem_addr  = inst_addr;
        if (sel == OWN_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
            mem_addr  = data_addr;
        end
    end

    assign inst_addr_ok = push & (sel == OWN_INST);
    assign data_addr_ok = push & (sel == OWN_DATA);

    // A cancel in the pop cycle also silences the head being popped.
    assign head_own     = own_q[rd_ptr];
    assign head_drop    = drop_q[rd_ptr] | inst_cancel;
    assign inst_data_ok = pop & ~head_own & ~head_drop;
    assign data_data_ok = pop & head_own;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign ot_cnt       = cnt;

    always_comb begin
        own_nxt  = own_q;
        drop_nxt = drop_q;
        if (inst_cancel)
            drop_nxt = drop_q | ~own_q;
        if (push) begin
            own_nxt[wr_ptr]  = (sel == OWN_DATA);
            drop_nxt[wr_ptr] = (sel == OWN_INST) & inst_cancel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            own_q  <= '0;
            drop_q <= '0;
        end else begin
            own_q  <= own_nxt;
            drop_q <= drop_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked   <= 1'b0;
            lock_own <= OWN_INST;
        end else if (push) begin
            locked <= 1'b0;
        end else if (mem_req && !mem_addr_ok) begin
            locked   <= 1'b1;
            lock_own <= sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            resp_err <= 1'b0;
        else if (mem_data_ok && empty)
            resp_err <= 1'b1;
    end

endmodule
